uart_rx_parity: RTL
===================

Name: uart_rx_parity

Overview:
- UART receive front end: oversamples the serial line, assembles LSB-first data frames, and checks the optional parity bit and the stop bit.
- Each completed frame is pushed into the RX FIFO with a one-cycle write strobe.
- Sits between the rx pin and the RX FIFO write port.
- Timing comes from the shared baud generator, which supplies a single-cycle s_tick at OVS times the baud rate.

Parameters:
- DBIT, 8, data bits per frame (5..8).
- OVS, 16, s_tick pulses per bit period (even, >=8).
- SB_TICK, 16, s_tick pulses spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial input, idle high, asynchronous to clk
- s_tick  in  1  oversample tick, one clk wide
- par_en  in  1  1 = frame carries a parity bit after the data
- par_odd  in  1  1 = odd parity, 0 = even parity; ignored when par_en=0
- fifo_full  in  1  full flag from the RX FIFO
- dout  out  DBIT  last received data word; feeds the FIFO data_w
- rx_done_tick  out  1  one-cycle pulse when a frame completes
- fifo_wr  out  1  rx_done_tick & ~fifo_full; feeds the FIFO wr
- parity_err  out  1  parity mismatch in the last frame
- frame_err  out  1  stop bit sampled low in the last frame
- overrun_err  out  1  last frame completed while fifo_full=1

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - All outputs go to 0. dout=0.
  - FSM goes to IDLE; tick and bit counters clear; shift register clears.
  - Both synchronizer flops reset to 1.
- rx passes through a 2-flop synchronizer, giving rx_s. All sampling uses rx_s, so the pin-to-FSM latency is 2 clk.
- The tick counter s (log2(SB_TICK) bits wide, minimum) advances only on cycles with s_tick=1. Cycles without a tick hold all state.
- FSM states and transitions:
  - IDLE: on rx_s=0, go to START with s=0. rx_s=0 already present when leaving reset also starts a frame.
  - START: on tick with s=OVS/2-1, sample rx_s at mid start bit.
    - rx_s=0: go to DATA, s=0, n=0.
    - rx_s=1: treat as a glitch and return to IDLE with no strobe and no flag change.
  - DATA: on tick with s=OVS-1, set s=0 and shift rx_s into the MSB of the DBIT shift register (LSB-first line order). Update the running parity (XOR). n increments.
    - After bit DBIT-1: go to PARITY if par_en=1, else to STOP.
  - PARITY: on tick with s=OVS-1, sample the parity bit p and set s=0, then go to STOP.
    - Error term = (XOR of data ^ p) != par_odd. Even parity: total ones including p must be even. Odd parity: total must be odd.
  - STOP: on tick with s=SB_TICK-1, sample rx_s.
    - Go to IDLE and assert rx_done_tick for exactly one clk on the following edge.
    - In that same edge, load dout from the shift register and load the three error flags.
- Output update rules:
  - par_en=0 forces parity_err=0.
  - frame_err = stop-bit sample was 0.
  - overrun_err = fifo_full at the done cycle.
  - dout and the error flags hold until the next rx_done_tick.
- fifo_wr is combinational from the registered rx_done_tick and fifo_full, so dout is stable in the same cycle as fifo_wr.
- Frames with parity or frame errors are still written; software uses the flags. When fifo_full=1, the frame is dropped: fifo_wr=0, overrun_err=1.
- par_en and par_odd are sampled continuously. Changing them mid-frame is undefined; they must be changed only in IDLE.
- A line held low through STOP (break) produces frame_err=1 and dout=0. The FSM then waits in IDLE. A new frame starts only after rx_s returns high and then falls again.
- Reset asserted mid-frame aborts immediately: no rx_done_tick, flags cleared.
- Back-to-back frames: a start edge arriving in the cycle STOP completes is detected from IDLE on the next cycle. No minimum idle gap is required beyond the stop period.

Test Plan:
1. OVS=16, par_en=0, send 0x55 with 1 stop bit -> exactly one rx_done_tick and one fifo_wr, dout=0x55, parity_err=frame_err=overrun_err=0.
2. par_en=1, par_odd=0, send 0xA3 with p=0 -> dout=0xA3, parity_err=0. Resend with p=1 -> parity_err=1, dout=0xA3, fifo_wr still pulses.
3. par_en=1, par_odd=1, send 0x01 with p=0 -> parity_err=0. Then send 0x00 with stop bit driven 0 -> frame_err=1, dout=0x00.
4. Low glitch on rx lasting 4 ticks -> no rx_done_tick, FSM back in IDLE. A following valid frame 0x3C is received correctly.
5. fifo_full=1 while frame 0x7E completes -> rx_done_tick=1, fifo_wr=0, overrun_err=1, dout=0x7E. Next frame with fifo_full=0 -> overrun_err=0.
6. Assert reset during data bit 3 of a frame -> all outputs 0, no strobe. After release, frame 0xC9 is received with dout=0xC9.

Source files
------------

// File: rtl/uart_rx_parity.sv
// UART receiver: 2-flop synced rx, oversampled start/data/parity/stop framing, one-cycle done strobe.
// Outputs are registered on the stop-sample tick; a full FIFO drops the frame (fifo_wr=0) and raises overrun_err.
module uart_rx_parity #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            par_en,
  input  logic            par_odd,
  input  logic            fifo_full,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            fifo_wr,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int SMAX = (SB_TICK > OVS) ? SB_TICK : OVS;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            par, par_next;
  logic            perr, perr_next;
  logic            brk, brk_next;
  logic            rx_m, rx_s;
  logic            done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      par   <= 1'b0;
      perr  <= 1'b0;
      brk   <= 1'b0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
      par   <= par_next;
      perr  <= perr_next;
      brk   <= brk_next;
    end
  end

  // brk holds off a new start after a low stop sample until the line has been seen high again.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    par_next   = par;
    perr_next  = perr;
    brk_next   = brk;
    case (state)
      IDLE: begin
        if (brk) begin
          if (rx_s) brk_next = 1'b0;
        end else if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
              par_next   = 1'b0;
              perr_next  = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next   = '0;
            b_next   = {rx_s, b[DBIT-1:1]};
            par_next = par ^ rx_s;
            if (n == N_LAST) state_next = par_en ? PARITY : STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next     = '0;
            perr_next  = ((par ^ rx_s) != par_odd);
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            s_next     = '0;
            brk_next   = !rx_s;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_nxt = (state == STOP) && s_tick && (s == S_STOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= done_nxt;
      if (done_nxt) begin
        dout        <= b;
        parity_err  <= par_en & perr;
        frame_err   <= ~rx_s;
        overrun_err <= fifo_full;
      end
    end
  end

  assign fifo_wr = rx_done_tick & ~fifo_full;

endmodule
